// File: rtl/op_sequencer.sv
// Multi-cycle instruction sequencer: fetch handshake, decode, execute through an
// external 20-bit datapath, write-back into an 8-entry register file.
module op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  op_sel,
  output logic [19:0] op_a,
  output logic [19:0] op_b,
  input  logic [19:0] op_res,
  output logic [19:0] pc,
  output logic        halted,
  output logic        illegal,
  input  logic [2:0]  dbg_addr,
  output logic [19:0] dbg_data
);

  localparam logic [4:0] OP_TRAP = 5'd0;
  localparam logic [4:0] OP_NOP  = 5'd1;
  localparam logic [4:0] OP_JMP  = 5'd2;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [19:0] result_q, result_d;
  logic [19:0] pc_q, pc_d;
  logic [19:0] regs_q [8];
  logic        wr_en;

  logic [4:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic        is_exec;
  logic [19:0] rs1_val, rs2_val;

  assign opcode  = instr_q[31:27];
  assign rd      = instr_q[26:24];
  assign rs1     = instr_q[23:21];
  assign rs2     = instr_q[20:18];
  assign is_exec = (opcode >= OP_NOT) && (opcode <= OP_SHR);

  // reg[0] is never written, so reading it through the array always yields 0
  assign rs1_val  = regs_q[rs1];
  assign rs2_val  = regs_q[rs2];
  assign dbg_data = regs_q[dbg_addr];
  assign pc       = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      pc_q     <= '0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      pc_q     <= pc_d;
      if (wr_en) begin
        regs_q[rd] <= result_q;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    result_d    = result_q;
    pc_d        = pc_q;
    wr_en       = 1'b0;
    instr_ready = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;
    op_sel      = '0;
    op_a        = '0;
    op_b        = '0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_sel = opcode;
        op_a   = rs1_val;
        op_b   = (opcode == OP_NOT) ? 20'd0 : rs2_val;
        if (opcode == OP_TRAP)  state_d = S_HALT;
        else if (is_exec)       state_d = S_EXEC;
        else                    state_d = S_WB;
      end
      S_EXEC: begin
        op_sel   = opcode;
        op_a     = rs1_val;
        op_b     = (opcode == OP_NOT) ? 20'd0 : rs2_val;
        result_d = op_res;
        state_d  = S_WB;
      end
      S_WB: begin
        // pc arithmetic relies on the 20-bit width to wrap 0xFFFFF -> 0
        if (opcode == OP_JMP) begin
          pc_d = instr_q[19:0];
        end else begin
          pc_d = pc_q + 20'd1;
        end
        if (is_exec) begin
          wr_en = (rd != 3'd0);
        end else if (opcode != OP_JMP && opcode != OP_NOP) begin
          illegal = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer with a behavioural datapath model on op_res;
// an injection override lets the bench preload registers through OR/XOR results.
module tb_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  op_sel;
  logic [19:0] op_a, op_b, op_res;
  logic [19:0] pc;
  logic        halted, illegal;
  logic [2:0]  dbg_addr;
  logic [19:0] dbg_data;

  logic        inject_en;
  logic [19:0] inject_val;
  logic [19:0] model_res;

  int n_cmp = 0;
  int n_bad = 0;

  op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .op_sel     (op_sel),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_res     (op_res),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (op_sel)
      5'd8:    model_res = ~op_a;
      5'd9:    model_res = op_a & op_b;
      5'd10:   model_res = op_a | op_b;
      5'd11:   model_res = op_a ^ op_b;
      5'd12:   model_res = op_a >> op_b[4:0];
      default: model_res = 20'd0;
    endcase
  end
  assign op_res = inject_en ? inject_val : model_res;

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
    return {op[4:0], rd[2:0], rs1[2:0], rs2[2:0], 18'd0};
  endfunction

  function automatic logic [31:0] jmp(input logic [19:0] target);
    return {5'd2, 7'd0, target};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rdchk(input string tag, input logic [2:0] idx, input logic [19:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Present one instruction; returns #1 after the handshake edge (DECODE cycle).
  task automatic issue(input logic [31:0] word);
    int k;
    k = 0;
    while (!instr_ready && k < 10) begin
      step(1);
      k++;
    end
    check("ready_wait", instr_ready, 1);
    instr       = word;
    instr_valid = 1'b1;
    step(1);
    instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    inject_en   = 1'b0;
    inject_val  = '0;

    step(2);
    check("rst_ready", instr_ready, 1);
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_opsel", op_sel, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy", instr_ready, 1);

    // Preload r1 = 0x0F0F0 (OR) and r2 = 0x00FF0 (XOR) via injected datapath results
    inject_en = 1'b1; inject_val = 20'h0F0F0;
    issue(mk(10, 1, 0, 0));
    check("or_opsel", op_sel, 10);
    step(3);
    rdchk("pre_r1", 3'd1, 20'h0F0F0);
    check("pre_pc1", pc, 1);
    inject_val = 20'h00FF0;
    issue(mk(11, 2, 0, 0));
    step(3);
    rdchk("pre_r2", 3'd2, 20'h00FF0);
    check("pre_pc2", pc, 2);
    inject_en = 1'b0;

    // AND r3 = r1 & r2, with latency check
    issue(mk(9, 3, 1, 2));
    check("and_opa", op_a, 20'h0F0F0);
    check("and_opb", op_b, 20'h00FF0);
    step(2);
    rdchk("and_r3_early", 3'd3, 20'h00000);
    check("and_rdy_wb", instr_ready, 0);
    step(1);
    rdchk("and_r3", 3'd3, 20'h000F0);
    check("and_pc", pc, 3);
    check("and_ready", instr_ready, 1);

    // NOT r4 = ~r1, op_b forced to 0
    issue(mk(8, 4, 1, 2));
    check("not_opb_dec", op_b, 0);
    check("not_opsel", op_sel, 8);
    step(1);
    check("not_opb_exe", op_b, 0);
    step(2);
    rdchk("not_r4", 3'd4, 20'hF0F0F);
    check("not_pc", pc, 4);

    // SHFTR r5 = r1 >> r4[4:0] (15); op_b carries the full register
    issue(mk(12, 5, 1, 4));
    step(1);
    check("shr_opb", op_b, 20'hF0F0F);
    step(2);
    rdchk("shr_r5", 3'd5, 20'h00001);
    check("shr_pc", pc, 5);

    // OR to r0 is discarded
    issue(mk(10, 0, 1, 2));
    step(3);
    rdchk("r0_zero", 3'd0, 20'h00000);
    rdchk("r1_keep", 3'd1, 20'h0F0F0);
    check("r0_pc", pc, 6);

    // JMP to 0xFFFFF then NOP wraps pc
    issue(jmp(20'hFFFFF));
    step(3);
    check("jmp_pc", pc, 20'hFFFFF);
    issue(mk(1, 0, 0, 0));
    step(3);
    check("wrap_pc", pc, 0);

    // Unsupported opcodes 5 and 20
    issue(mk(5, 3, 1, 2));
    check("ill5_dec", illegal, 0);
    step(1);
    check("ill5_pulse", illegal, 1);
    step(1);
    check("ill5_clear", illegal, 0);
    check("ill5_pc", pc, 1);
    rdchk("ill5_r3", 3'd3, 20'h000F0);
    issue(mk(20, 4, 1, 2));
    step(1);
    check("ill20_pulse", illegal, 1);
    step(1);
    check("ill20_clear", illegal, 0);
    check("ill20_pc", pc, 2);
    rdchk("ill20_r4", 3'd4, 20'hF0F0F);

    // TRAP at pc 7
    issue(jmp(20'd7));
    step(3);
    check("jmp7_pc", pc, 7);
    issue(mk(0, 0, 0, 0));
    check("trap_dec_halt", halted, 0);
    step(1);
    check("trap_halted", halted, 1);
    instr       = mk(1, 0, 0, 0);
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("halt_ready", instr_ready, 0);
      check("halt_pc", pc, 7);
      step(1);
    end
    check("halt_still", halted, 1);
    rst_n = 1'b0;
    #1;
    check("trap_rst_pc", pc, 0);
    check("trap_rst_halt", halted, 0);
    instr_valid = 1'b0;
    step(1);
    rst_n = 1'b1;
    #1;
    check("trap_rst_rdy", instr_ready, 1);
    rdchk("trap_rst_r1", 3'd1, 20'h00000);

    // Reset during EXEC of AND r3 aborts the write
    inject_en = 1'b1; inject_val = 20'h0F0F0;
    issue(mk(10, 1, 0, 0));
    step(3);
    inject_val = 20'h00FF0;
    issue(mk(11, 2, 0, 0));
    step(3);
    inject_en = 1'b0;
    check("abort_pre_pc", pc, 2);
    issue(mk(9, 3, 1, 2));
    step(1);
    check("abort_in_exec", op_sel, 9);
    rst_n = 1'b0;
    #1;
    check("abort_opsel", op_sel, 0);
    check("abort_pc", pc, 0);
    rdchk("abort_r3", 3'd3, 20'h00000);
    step(2);
    rdchk("abort_r3_late", 3'd3, 20'h00000);
    rst_n = 1'b1;
    #1;
    check("abort_ready", instr_ready, 1);
    issue(mk(1, 0, 0, 0));
    step(3);
    check("abort_nop_pc", pc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
